led_scan_ctrl: RTL and testbench

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

---
 rtl/led_panel_pkg.sv | 24 ++
 rtl/led_fb_ram.sv | 48 ++++
 rtl/led_scan_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_led_scan_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_panel_pkg.sv
// Shared types and defaults for the LED panel scan controller.
package led_panel_pkg;

  localparam int unsigned COLS_DEF      = 32;
  localparam int unsigned ROWS_DEF      = 4;
  localparam int unsigned ON_CYCLES_DEF = 64;

  // One pixel, packed as {r,g,b}.
  typedef logic [2:0] pixel_t;

  // The state names the action taken on the next tick.
  typedef enum logic [1:0] {
    StShiftLo,
    StShiftHi,
    StLatch,
    StDisplay
  } scan_state_e;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_fb_ram.sv
// Framebuffer: one write port and one registered read port. Reading and writing the
// same word in one cycle returns the old contents.
module led_fb_ram
  import led_panel_pkg::*;
#(
  parameter int unsigned Depth = 128,
  parameter int unsigned Aw    = 7
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          we_i,
  input  logic [Aw-1:0] waddr_i,
  input  pixel_t        wdata_i,
  input  logic          re_i,
  input  logic [Aw-1:0] raddr_i,
  output pixel_t        rdata_o
);

  pixel_t mem_q [Depth];
  pixel_t rdata_q, rdata_d;

  // Storage write; contents survive reset.
  always_ff @(posedge CLK) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register only loads when a fetch is requested, otherwise holds.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  // Read register state.
  always_ff @(posedge CLK) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/led_scan_ctrl.sv
// HUB75-style row scan controller. Each row: shift COLS pixels, latch, then light the
// row for ON_CYCLES ticks. Define LED_SCAN_DOUBLE_BUFFER_EN for front/back banks with
// swap at frame end; otherwise a single bank is written and displayed directly.
module led_scan_ctrl
  import led_panel_pkg::*;
#(
  parameter int unsigned COLS      = COLS_DEF,
  parameter int unsigned ROWS      = ROWS_DEF,
  parameter int unsigned ON_CYCLES = ON_CYCLES_DEF
) (
  input  logic                             CLK,
  input  logic                             rst,
  input  logic                             tick,
  input  logic                             wr_en,
  // One spare code point so an out-of-range address can be presented and rejected.
  input  logic [$clog2(ROWS*COLS+1)-1:0]   wr_addr,
  input  logic [2:0]                       wr_data,
  input  logic                             swap_req,
  output logic                             swap_ack,
  output logic                             frame_start,
  output logic                             red,
  output logic                             green,
  output logic                             blue,
  output logic                             sclk,
  output logic                             latch,
  output logic                             blank,
  output logic                             a,
  output logic                             b
);

  localparam int unsigned Pixels = ROWS * COLS;
`ifdef LED_SCAN_DOUBLE_BUFFER_EN
  localparam int unsigned Banks = 2;
`else
  localparam int unsigned Banks = 1;
`endif
  localparam int unsigned Depth = Banks * Pixels;
  localparam int unsigned RamAw = clog2_min1(Depth);
  localparam int unsigned Cw    = clog2_min1(COLS);
  localparam int unsigned Dw    = clog2_min1(ON_CYCLES);

  scan_state_e    state_q, state_d;
  logic [1:0]     row_q, row_d;
  logic [Cw-1:0]  col_q, col_d;
  logic [Dw-1:0]  cnt_q, cnt_d;
  logic           sclk_q, sclk_d;
  logic           latch_q, latch_d;
  logic           blank_q, blank_d;
  logic [1:0]     ba_q, ba_d;
  logic           frame_start_q, frame_start_d;

  logic             rd_en, rd_bank, wr_bank, wr_ok;
  logic [RamAw-1:0] rd_idx, wr_idx;
  pixel_t           pix;

`ifdef LED_SCAN_DOUBLE_BUFFER_EN
  logic front_q, front_d;
  logic swap_ack_q, swap_ack_d;
  logic frame_end;

  assign frame_end = tick && (state_q == StDisplay) && (row_q == 2'd3) &&
                     (cnt_q == Dw'(ON_CYCLES - 1));

  // Banks exchange only on the last lit tick of row 3, so a frame never mixes banks.
  always_comb begin
    front_d    = front_q;
    swap_ack_d = 1'b0;
    if (frame_end && swap_req) begin
      front_d    = ~front_q;
      swap_ack_d = 1'b1;
    end
  end

  // Bank select and acknowledge registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      front_q    <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      front_q    <= front_d;
      swap_ack_q <= swap_ack_d;
    end
  end

  assign rd_bank  = front_q;
  assign wr_bank  = ~front_q;
  assign swap_ack = swap_ack_q;
`else
  logic unused_swap_req;
  assign unused_swap_req = swap_req;
  assign rd_bank  = 1'b0;
  assign wr_bank  = 1'b0;
  assign swap_ack = 1'b0;
`endif

  assign wr_ok  = wr_en && !rst && (32'(wr_addr) < Pixels);
  assign wr_idx = RamAw'(32'(wr_bank) * Pixels + 32'(wr_addr));
  assign rd_idx = RamAw'(32'(rd_bank) * Pixels + 32'(row_q) * COLS + 32'(col_q));

  led_fb_ram #(
    .Depth (Depth),
    .Aw    (RamAw)
  ) u_fb_ram (
    .CLK     (CLK),
    .rst     (rst),
    .we_i    (wr_ok),
    .waddr_i (wr_idx),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .raddr_i (rd_idx),
    .rdata_o (pix)
  );

  // Scan sequencer: on each tick perform the current state's action and pick the next.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    cnt_d         = cnt_q;
    sclk_d        = sclk_q;
    latch_d       = latch_q;
    blank_d       = blank_q;
    ba_d          = ba_q;
    frame_start_d = 1'b0;
    rd_en         = 1'b0;
    if (tick) begin
      unique case (state_q)
        StShiftLo: begin
          sclk_d        = 1'b0;
          latch_d       = 1'b0;
          blank_d       = 1'b1;
          rd_en         = 1'b1;
          frame_start_d = (row_q == 2'd0) && (col_q == '0);
          state_d       = StShiftHi;
        end
        StShiftHi: begin
          sclk_d  = 1'b1;
          latch_d = 1'b0;
          blank_d = 1'b1;
          if (col_q == Cw'(COLS - 1)) begin
            state_d = StLatch;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = StShiftLo;
          end
        end
        StLatch: begin
          sclk_d  = 1'b0;
          latch_d = 1'b1;
          blank_d = 1'b1;
          ba_d    = row_q;
          state_d = StDisplay;
        end
        StDisplay: begin
          sclk_d  = 1'b0;
          latch_d = 1'b0;
          blank_d = 1'b0;
          if (cnt_q == Dw'(ON_CYCLES - 1)) begin
            cnt_d   = '0;
            col_d   = '0;
            row_d   = row_q + 2'd1;
            state_d = StShiftLo;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StShiftLo;
      endcase
    end
  end

  // Sequencer and panel drive registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q       <= StShiftLo;
      row_q         <= 2'd0;
      col_q         <= '0;
      cnt_q         <= '0;
      sclk_q        <= 1'b0;
      latch_q       <= 1'b0;
      blank_q       <= 1'b1;
      ba_q          <= 2'd0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      cnt_q         <= cnt_d;
      sclk_q        <= sclk_d;
      latch_q       <= latch_d;
      blank_q       <= blank_d;
      ba_q          <= ba_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign red         = pix[2];
  assign green       = pix[1];
  assign blue        = pix[0];
  assign sclk        = sclk_q;
  assign latch       = latch_q;
  assign blank       = blank_q;
  assign a           = ba_q[0];
  assign b           = ba_q[1];
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl. The reference model derives every output from
// the tick count since reset (row = tick / period, phase = tick % period) and a plain
// array image of the framebuffer banks.
module tb_led_scan_ctrl;

  localparam int COLS = 32;
  localparam int ROWS = 4;
  localparam int ON   = 64;
  localparam int PIX  = ROWS * COLS;
  localparam int P    = 2 * COLS + 1 + ON;
  localparam int AW   = $clog2(PIX + 1);
`ifdef LED_SCAN_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          rst, tick, wr_en, swap_req;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic          swap_ack, frame_start, red, green, blue, sclk, latch, blank, a, b;
  logic [9:0]    obs;

  assign obs = {red, green, blue, sclk, latch, blank, b, a, swap_ack, frame_start};

  led_scan_ctrl #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .ON_CYCLES (ON)
  ) dut (
    .CLK         (CLK),
    .rst         (rst),
    .tick        (tick),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .frame_start (frame_start),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .sclk        (sclk),
    .latch       (latch),
    .blank       (blank),
    .a           (a),
    .b           (b)
  );

  always #5 CLK = ~CLK;

  int n_vec;
  int n_err;

  // Reference model state
  logic [2:0] fb       [2][PIX];
  bit         fb_known [2][PIX];
  int         k;
  bit         m_front;
  logic [2:0] m_rgb;
  bit         m_rgb_known;
  bit         m_sclk, m_latch, m_blank, m_fs, m_ack;
  bit   [1:0] m_ba;
  logic [9:0] m_exp, m_msk;

  // Drive one CLK of stimulus, advance the model, and sample #1 after the edge.
  task automatic clk_cycle(input bit r, input bit t, input bit we, input int addr,
                           input logic [2:0] data, input bit sreq);
    int phase, row, wb;
    bit do_swap;
    rst = r; tick = t; wr_en = we; wr_addr = AW'(addr); wr_data = data; swap_req = sreq;
    do_swap = 1'b0;
    m_fs    = 1'b0;
    m_ack   = 1'b0;
    if (r) begin
      k = 0; m_front = 1'b0; m_rgb = 3'b000; m_rgb_known = 1'b1;
      m_sclk = 1'b0; m_latch = 1'b0; m_blank = 1'b1; m_ba = 2'b00;
    end else begin
      if (t) begin
        phase = k % P;
        row   = (k / P) % 4;
        if (phase < 2 * COLS) begin
          m_sclk  = (phase % 2 == 1);
          m_blank = 1'b1;
          m_latch = 1'b0;
          if (phase % 2 == 0) begin
            m_rgb       = fb[int'(m_front)][row * COLS + phase / 2];
            m_rgb_known = fb_known[int'(m_front)][row * COLS + phase / 2];
            m_fs        = (phase == 0) && (row == 0);
          end
        end else if (phase == 2 * COLS) begin
          m_sclk = 1'b0; m_latch = 1'b1; m_blank = 1'b1; m_ba = 2'(row);
        end else begin
          m_sclk = 1'b0; m_latch = 1'b0; m_blank = 1'b0;
          if (DB && phase == P - 1 && row == 3 && sreq) begin
            do_swap = 1'b1;
            m_ack   = 1'b1;
          end
        end
        k++;
      end
      if (we && addr < PIX) begin
        wb = DB ? (m_front ? 0 : 1) : 0;
        fb[wb][addr]       = data;
        fb_known[wb][addr] = 1'b1;
      end
      if (do_swap) m_front = !m_front;
    end
    m_exp = {m_rgb, m_sclk, m_latch, m_blank, m_ba[1], m_ba[0], m_ack, m_fs};
    m_msk = {{3{m_rgb_known}}, 7'h7f};
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      clk_cycle(1'b1, 1'($urandom), 1'($urandom), int'($urandom_range(0, PIX)),
                3'($urandom), 1'($urandom));
      n_vec++;
      if (obs !== 10'h010) begin
        n_err++;
        $display("FAIL reset_values obs=%b want=%b", obs, 10'h010);
      end
    end
    clk_cycle(1'b0, 1'b0, 1'b0, 0, 3'b000, 1'b0);
    n_vec++;
    if ((obs & m_msk) !== (m_exp & m_msk)) begin
      n_err++;
      $display("FAIL reset_hold obs=%b want=%b", obs, m_exp);
    end
  endtask

  // tick held low while the image is written; outputs must not move.
  task automatic test_fill(input bit all_green);
    logic [2:0] d;
    for (int ad = 0; ad < PIX; ad++) begin
      d = all_green ? 3'b010 : 3'($urandom);
      if (!all_green && ad == 0) d = 3'b100;
      clk_cycle(1'b0, 1'b0, 1'b1, ad, d, 1'b0);
      n_vec++;
      if ((obs & m_msk) !== (m_exp & m_msk)) begin
        n_err++;
        $display("FAIL fill addr=%0d obs=%b want=%b", ad, obs, m_exp);
      end
    end
  endtask

  task automatic test_swap();
    int acks, k_ack, greens;
    bit sreq;
    acks = 0; k_ack = -1; greens = 0;
    clk_cycle(1'b1, 1'b0, 1'b0, 0, 3'b000, 1'b0);
    for (int i = 0; i < 8 * P + 2; i++) begin
      sreq = (k >= 2 * P) && (acks == 0);
      clk_cycle(1'b0, 1'b1, 1'b0, 0, 3'b000, sreq);
      n_vec++;
      if ((obs & m_msk) !== (m_exp & m_msk)) begin
        n_err++;
        $display("FAIL swap k=%0d obs=%b want=%b", k, obs, m_exp);
      end
      if (swap_ack) begin acks++; k_ack = k; end
      if (k > 4 * P && k <= 8 * P && sclk && {red, green, blue} == 3'b010) greens++;
    end
    n_vec++;
    if (acks !== 1) begin n_err++; $display("FAIL swap_ack_count got=%0d want=1", acks); end
    n_vec++;
    if (k_ack !== 4 * P) begin
      n_err++;
      $display("FAIL swap_ack_time got=%0d want=%0d", k_ack, 4 * P);
    end
    n_vec++;
    if (greens !== PIX) begin
      n_err++;
      $display("FAIL swap_green_cols got=%0d want=%0d", greens, PIX);
    end
  endtask

  task automatic test_first_row();
    int rises, latches, dark;
    bit prev_sclk;
    rises = 0; latches = 0; dark = 0; prev_sclk = 1'b0;
    clk_cycle(1'b1, 1'b1, 1'b0, 0, 3'b000, 1'b0);
    for (int i = 0; i < P; i++) begin
      clk_cycle(1'b0, 1'b1, 1'b0, 0, 3'b000, 1'b0);
      n_vec++;
      if ((obs & m_msk) !== (m_exp & m_msk)) begin
        n_err++;
        $display("FAIL first_row i=%0d obs=%b want=%b", i, obs, m_exp);
      end
      if (i == 0) begin
        n_vec++;
        if ({red, green, blue, frame_start} !== 4'b1001) begin
          n_err++;
          $display("FAIL first_pixel got=%b want=1001", {red, green, blue, frame_start});
        end
      end
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
      if (latch) latches++;
      if (!blank) dark++;
    end
    n_vec++;
    if (rises !== COLS) begin n_err++; $display("FAIL sclk_rises got=%0d want=%0d", rises, COLS); end
    n_vec++;
    if (latches !== 1) begin n_err++; $display("FAIL latch_len got=%0d want=1", latches); end
    n_vec++;
    if (dark !== ON) begin n_err++; $display("FAIL blank_low got=%0d want=%0d", dark, ON); end
  endtask

  task automatic test_slow_tick();
    int fs_cnt, fs_first, fs_second;
    bit prev_latch, we;
    logic [1:0] ba_seen[$];
    fs_cnt = 0; fs_first = -1; fs_second = -1; prev_latch = 1'b0;
    clk_cycle(1'b1, 1'b0, 1'b0, 0, 3'b000, 1'b0);
    for (int i = 0; i < (4 * P + 1) * 4; i++) begin
      we = ($urandom_range(0, 3) == 0);
      clk_cycle(1'b0, (i % 4 == 0), we, int'($urandom_range(0, PIX)), 3'($urandom), 1'b0);
      n_vec++;
      if ((obs & m_msk) !== (m_exp & m_msk)) begin
        n_err++;
        $display("FAIL slow_tick i=%0d obs=%b want=%b", i, obs, m_exp);
      end
      if (frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i; else fs_second = i;
      end
      if (latch && !prev_latch) ba_seen.push_back({b, a});
      prev_latch = latch;
    end
    n_vec++;
    if (fs_cnt !== 2) begin n_err++; $display("FAIL frame_start_count got=%0d want=2", fs_cnt); end
    n_vec++;
    if (fs_second - fs_first !== 16 * P) begin
      n_err++;
      $display("FAIL frame_period got=%0d want=%0d", fs_second - fs_first, 16 * P);
    end
    n_vec++;
    if (ba_seen.size() !== 4) begin
      n_err++;
      $display("FAIL latch_count got=%0d want=4", ba_seen.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_vec++;
        if (ba_seen[j] !== 2'(j)) begin
          n_err++;
          $display("FAIL row_addr j=%0d got=%b want=%b", j, ba_seen[j], 2'(j));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    clk_cycle(1'b1, 1'b0, 1'b0, 0, 3'b000, 1'b0);
    while (!(((k / P) % 4 == 2) && (k % P > 2 * COLS + 10)) && guard < 4 * P) begin
      clk_cycle(1'b0, 1'b1, 1'b0, 0, 3'b000, 1'b0);
      n_vec++;
      if ((obs & m_msk) !== (m_exp & m_msk)) begin
        n_err++;
        $display("FAIL pre_reset k=%0d obs=%b want=%b", k, obs, m_exp);
      end
      guard++;
    end
    n_vec++;
    if (guard >= 4 * P) begin n_err++; $display("FAIL reach_row2 got=%0d want<%0d", guard, 4 * P); end
    clk_cycle(1'b1, 1'b1, 1'b1, int'($urandom_range(0, PIX - 1)), 3'($urandom), 1'b0);
    n_vec++;
    if ({blank, b, a, latch} !== 4'b1000) begin
      n_err++;
      $display("FAIL mid_reset got=%b want=1000", {blank, b, a, latch});
    end
    for (int i = 0; i < 4 * P + 2; i++) begin
      clk_cycle(1'b0, 1'b1, 1'b0, 0, 3'b000, 1'b0);
      n_vec++;
      if ((obs & m_msk) !== (m_exp & m_msk)) begin
        n_err++;
        $display("FAIL post_reset i=%0d obs=%b want=%b", i, obs, m_exp);
      end
    end
  endtask

  task automatic test_oob();
    clk_cycle(1'b1, 1'b0, 1'b0, 0, 3'b000, 1'b0);
    for (int i = 0; i < 4 * P + 1; i++) begin
      clk_cycle(1'b0, 1'b1, 1'b1, PIX, 3'($urandom), 1'b0);
      n_vec++;
      if ((obs & m_msk) !== (m_exp & m_msk)) begin
        n_err++;
        $display("FAIL oob_write i=%0d obs=%b want=%b", i, obs, m_exp);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      clk_cycle(1'b0, 1'($urandom), 1'($urandom), int'($urandom_range(0, PIX)),
                3'($urandom), 1'($urandom));
      n_vec++;
      if ((obs & m_msk) !== (m_exp & m_msk)) begin
        n_err++;
        $display("FAIL random i=%0d obs=%b want=%b", i, obs, m_exp);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    k = 0;
    m_front = 1'b0;
    for (int bk = 0; bk < 2; bk++) begin
      for (int p = 0; p < PIX; p++) begin
        fb[bk][p]       = 3'b000;
        fb_known[bk][p] = 1'b0;
      end
    end
    rst = 1'b1; tick = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = 3'b000; swap_req = 1'b0;
    test_reset();
`ifdef LED_SCAN_DOUBLE_BUFFER_EN
    test_fill(1'b1);
    test_swap();
`endif
    test_fill(1'b0);
    test_first_row();
    test_slow_tick();
    test_reset_mid();
    test_oob();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
